// File: rtl/fft_pkg.sv
// Types and sizes shared by the FFT frame sequencer and the stage modules it drives.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FINISH = 3'd3,
        ABORT  = 3'd4
    } seq_state_t;

    localparam int FFT_BUF_AW   = 12;
    localparam int FFT_SAMPLE_W = 16;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage hang detector: counts enabled cycles since the last clear and
// flags the last allowed cycle so the sequencer can abort on the next edge.
module stage_watchdog #(
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Frame controller for the hannify -> ffter -> cart_to_polar chain: launches each
// stage in turn, ping-pongs the sample bank, and records frames, overruns and hangs.
//
//   state  | meaning
//   IDLE   | no frame in flight; accepts a new or pending frame when enabled
//   LAUNCH | one-cycle go pulse to stage idx, watchdog cleared
//   WAIT   | waiting for done of stage idx, watchdog running
//   FINISH | last stage done; frame_done pulse, frame counted
//   ABORT  | stage hung; sticky timeout_err, frame discarded
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int TIMEOUT_CYC = 16384,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_ready,
    input  logic                  enable,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic                  bank_sel,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout_err,
    input  logic                  err_clr,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      overrun_cnt
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic                  pending;
    logic [NUM_STAGES-1:0] done_q;
    logic                  wd_expired;
    logic                  accept;
    logic                  drop_frame;
    logic                  cur_done;

    // Done pulses are registered once, which also places the next go two cycles after a done.
    always_comb begin
        cur_done = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_done = done_q[k];
            end
        end
    end

    always_comb begin
        stage_go = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_go[k] = (state == LAUNCH) && (idx == IDX_W'(k));
        end
    end

    assign accept     = (state == IDLE) && (frame_ready || pending) && enable;
    // A disabled idle sequencer ignores frames outright; everywhere else a second waiting frame is lost.
    assign drop_frame = frame_ready && pending && ((state != IDLE) || enable);

    stage_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state != WAIT),
        .en     (state == WAIT),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            done_q      <= '0;
            bank_sel    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            done_q     <= stage_done;
            frame_done <= 1'b0;

            if (accept) begin
                pending <= 1'b0;
            end else if ((state != IDLE) && frame_ready) begin
                pending <= 1'b1;
            end

            // A coincident clear still records the new drop.
            if (drop_frame) begin
                if (err_clr) begin
                    overrun_cnt <= CNT_W'(1);
                end else if (overrun_cnt != '1) begin
                    overrun_cnt <= overrun_cnt + 1'b1;
                end
            end else if (err_clr) begin
                overrun_cnt <= '0;
            end

            if (state == ABORT) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        bank_sel <= ~bank_sel;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (cur_done) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LAUNCH;
                        end
                    end else if (wd_expired) begin
                        state <= ABORT;
                    end
                end
                FINISH: begin
                    frame_cnt <= frame_cnt + 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                ABORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
